load_unit: RTL
==============

# load_unit

Load-side counterpart to the store-data formatter: accepts a decoded RISC-V load (opcode 0000011) from the execute stage and issues a word-aligned read to data memory over a request/grant/rvalid handshake. It extracts the addressed byte, halfword or word from the returned word, sign- or zero-extends it per funct3, and holds the result for writeback under a valid/ready handshake. Misaligned or illegal loads and memory timeouts are reported through an error flag without a memory access or with a zero result.

## Interface
- MEM_TIMEOUT, 255: WAIT cycles without mem_rvalid before the load is aborted with error (1..65535).
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  load request present.
- req_ready  output  1  unit can accept a request.
- opcode  input  7  instruction opcode.
- funct3  input  3  load width/sign select.
- addr  input  32  effective byte address.
- rd  input  5  destination register tag.
- mem_req  output  1  memory read request.
- mem_addr  output  32  word address, {addr[31:2],2'b00}.
- mem_gnt  input  1  memory accepts mem_req this cycle.
- mem_rvalid  input  1  mem_rdata valid this cycle.
- mem_rdata  input  32  read word, little-endian.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  writeback consumes result.
- rsp_data  output  32  extended load result.
- rsp_rd  output  5  tag of the result.
- rsp_err  output  1  misaligned/illegal/timeout.

## Operation
- States: IDLE, REQ, WAIT, RESP. req_ready = (state==IDLE) && !reset.
- IDLE: on req_valid&&req_ready, capture funct3, addr[1:0], rd, and word address.
  - opcode != 0000011: request consumed and dropped; stay IDLE; no response.
  - funct3 in {011,110,111}, lh/lhu with addr[0]=1, or lw with addr[1:0]!=0: go to RESP, rsp_err=1, rsp_data=0, no memory access.
  - Otherwise go to REQ.
- REQ: mem_req=1 and mem_addr stable until mem_gnt. On mem_gnt, clear the timeout counter and go to WAIT.
- WAIT: on mem_rvalid, register the extracted data and go to RESP with rsp_err=0. Otherwise increment the counter. When the counter reaches MEM_TIMEOUT, go to RESP with rsp_err=1 and rsp_data=0.
- RESP: rsp_valid=1. rsp_data, rsp_rd and rsp_err are stable until rsp_ready. On rsp_ready, go to IDLE.
- Extraction, with b = addr[1:0]:
  - 000 lb: sign-extend mem_rdata[8b+7:8b].
  - 100 lbu: zero-extend mem_rdata[8b+7:8b].
  - 001 lh: sign-extend mem_rdata[16·addr[1]+15 : 16·addr[1]].
  - 101 lhu: zero-extend the same halfword.
  - 010 lw: mem_rdata unchanged.
- mem_gnt and mem_rvalid are ignored outside REQ and WAIT respectively.
- After a timeout, a late rvalid is a system fault and is not filtered if it lands in a later WAIT.
- Counter width: clog2(MEM_TIMEOUT+1). It saturates and does not wrap.

## Timing
- Reset values: state IDLE; mem_req=0, mem_addr=0, rsp_valid=0, rsp_data=0, rsp_rd=0, rsp_err=0, counter=0.
- Reset asserted mid-operation: abandon immediately. mem_req drops asynchronously, and any in-flight rvalid is ignored.
- All outputs are registered except req_ready.
- Minimum legal-load latency: accept at edge 0; mem_req high in cycle 1 with mem_gnt; mem_rvalid in cycle 2; rsp_valid in cycle 3.
  - mem_rvalid is never valid in the same cycle as mem_gnt.
- Illegal/misaligned: rsp_valid the cycle after accept.
- rsp_ready asserted in the first RESP cycle returns to IDLE the next cycle. Peak throughput: one load per 4 cycles.
- Timeout: with mem_gnt in cycle g and no rvalid, rsp_valid/rsp_err rise at cycle g+1+MEM_TIMEOUT.

## Test plan
- lb at addr 0x1003, mem_rdata=0x80FF_1234 -> mem_addr=0x1000; rsp_data=0xFFFF_FF80, rsp_err=0, rsp_valid at cycle 3 with zero-wait memory.
- lhu at addr 0x2002, mem_rdata=0x9ABC_5678 -> rsp_data=0x0000_9ABC. lh at the same address -> 0xFFFF_9ABC.
- lw at 0x3001 -> no mem_req, rsp_err=1, rsp_data=0, rsp_valid the cycle after accept. funct3=011 gives the same result.
- lw at 0x4000, mem_gnt held low 5 cycles, then rvalid after 3 more, rsp_ready low 4 cycles -> mem_req/mem_addr stable throughout; rsp_data=mem_rdata; rsp outputs stable until consumed; req_ready=0 the whole time.
- MEM_TIMEOUT=4, grant then no rvalid -> rsp_err=1, rsp_data=0 exactly 5 cycles after grant. A stray rvalid in IDLE is ignored.
- Reset asserted while in WAIT -> mem_req=0 and rsp_valid=0 immediately. After release, a new lbu at 0x10 with rdata 0x0000_00AB returns 0x0000_00AB.

Source files
------------

// File: rtl/load_unit.sv
// load_unit: accepts decoded RISC-V loads, issues a word-aligned memory read
// over req/gnt/rvalid, extracts and extends the addressed byte/halfword/word,
// and returns the result under a valid/ready handshake with an error flag.
module load_unit #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [4:0]  rd,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [4:0]  rsp_rd,
    output logic        rsp_err
);

    localparam int unsigned CNT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [6:0]  OP_LOAD = 7'b0000011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t             r_state;
    logic [2:0]         r_f3;
    logic [1:0]         r_off;
    logic [4:0]         r_rd;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_mem_req;
    logic [31:0]        r_mem_addr;
    logic               r_rsp_valid;
    logic [31:0]        r_rsp_data;
    logic [4:0]         r_rsp_rd;
    logic               r_rsp_err;

    logic               w_illegal;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_ext;
    logic [CNT_W-1:0]   w_cnt_nxt;

    assign req_ready = (r_state == S_IDLE) && !reset;
    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_rd    = r_rsp_rd;
    assign rsp_err   = r_rsp_err;

    // Reserved widths and misaligned halfword/word accesses never reach memory
    always_comb begin
        w_illegal = 1'b1;
        case (funct3)
            3'b000, 3'b100: w_illegal = 1'b0;
            3'b001, 3'b101: w_illegal = addr[0];
            3'b010:         w_illegal = (addr[1:0] != 2'b00);
            default:        w_illegal = 1'b1;
        endcase
    end

    // Select the addressed lane of the returned word and extend it per funct3
    always_comb begin
        w_byte = 8'(mem_rdata >> {r_off, 3'b000});
        w_half = 16'(mem_rdata >> {r_off[1], 4'b0000});
        w_ext  = mem_rdata;
        case (r_f3)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_ext = {24'h000000, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b101:  w_ext = {16'h0000, w_half};
            default: w_ext = mem_rdata;
        endcase
    end

    // Saturating wait-cycle count; the terminal value triggers the timeout
    assign w_cnt_nxt = (r_cnt == CNT_W'(MEM_TIMEOUT)) ? r_cnt : r_cnt + CNT_W'(1);

    // Load sequencer: IDLE -> REQ -> WAIT -> RESP, with direct IDLE -> RESP on illegal
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_f3        <= 3'b000;
            r_off       <= 2'b00;
            r_rd        <= 5'd0;
            r_cnt       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 32'h0;
            r_rsp_rd    <= 5'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid && (opcode == OP_LOAD)) begin
                        r_f3       <= funct3;
                        r_off      <= addr[1:0];
                        r_rd       <= rd;
                        r_mem_addr <= {addr[31:2], 2'b00};
                        if (w_illegal) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_data  <= 32'h0;
                            r_rsp_rd    <= rd;
                        end else begin
                            r_state   <= S_REQ;
                            r_mem_req <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_gnt) begin
                        r_mem_req <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_data  <= w_ext;
                        r_rsp_rd    <= r_rd;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                        if (w_cnt_nxt == CNT_W'(MEM_TIMEOUT)) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_data  <= 32'h0;
                            r_rsp_rd    <= r_rd;
                        end
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
